// File: rtl/rs_10_8_pkg.sv
// rs_10_8_pkg: GF(2^8) constants, types and multiplier shared by the RS(10,8)
// encoder and decoder.
package rs_10_8_pkg;
    localparam int SYM_W = 8;
    localparam int N_SYM = 10;
    localparam int K_SYM = 8;
    localparam logic [8:0] PRIM_POLY = 9'h11D;

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [N_SYM*SYM_W-1:0] codeword_t;

    localparam sym_t G1 = 8'h03;
    localparam sym_t G0 = 8'h02;

    // Shift-and-add multiply, reducing by the primitive polynomial each step
    function automatic sym_t gmul(sym_t a, sym_t b);
        sym_t p;
        sym_t x;
        p = '0;
        x = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p ^= x;
            x = x[SYM_W-1] ? ((x << 1) ^ PRIM_POLY[SYM_W-1:0]) : (x << 1);
        end
        return p;
    endfunction
endpackage

// File: rtl/rs_10_8_encoder_seq_lfsr_step.sv
// rs_lfsr_step: one symbol of the g(x) = x^2 + 3x + 2 division LFSR.
module rs_lfsr_step
    import rs_10_8_pkg::*;
(
    input  logic [7:0] d,
    input  logic [7:0] r1,
    input  logic [7:0] r0,
    output logic [7:0] r1_next,
    output logic [7:0] r0_next
);
    logic [7:0] fb;

    assign fb      = d ^ r1;
    assign r1_next = r0 ^ gmul(fb, G1);
    assign r0_next = gmul(fb, G0);
endmodule

// File: rtl/rs_10_8_encoder_seq.sv
// rs_10_8_encoder_seq: systematic RS(10,8) encoder, symbol-serial LFSR with
// valid/ready handshakes on both the data and codeword sides.
module rs_10_8_encoder_seq
    import rs_10_8_pkg::*;
#(
    parameter int SYMS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] codeword_out,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ENC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [63:0] hold;
    logic [63:0] shreg;
    logic [7:0]  r1;
    logic [7:0]  r0;
    logic [2:0]  cnt;
    logic [7:0]  c1 [SYMS_PER_CYCLE+1];
    logic [7:0]  c0 [SYMS_PER_CYCLE+1];
    logic        last;

    assign c1[0] = r1;
    assign c0[0] = r0;

    // Symbols are taken MSB-first from the top of the shift register
    for (genvar g = 0; g < SYMS_PER_CYCLE; g++) begin : g_step
        rs_lfsr_step u_step (
            .d       (shreg[63-8*g -: 8]),
            .r1      (c1[g]),
            .r0      (c0[g]),
            .r1_next (c1[g+1]),
            .r0_next (c0[g+1])
        );
    end

    assign last     = cnt == 3'(K_SYM - SYMS_PER_CYCLE);
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            shreg        <= '0;
            r1           <= '0;
            r0           <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            codeword_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    hold  <= data_in;
                    shreg <= data_in;
                    r1    <= '0;
                    r0    <= '0;
                    cnt   <= '0;
                    state <= ENC;
                end
                ENC: begin
                    shreg <= shreg << (8 * SYMS_PER_CYCLE);
                    r1    <= c1[SYMS_PER_CYCLE];
                    r0    <= c0[SYMS_PER_CYCLE];
                    cnt   <= cnt + 3'(SYMS_PER_CYCLE);
                    if (last) begin
                        codeword_out <= {hold, c1[SYMS_PER_CYCLE], c0[SYMS_PER_CYCLE]};
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
